// File: rtl/fetch_queue.sv
// Instruction fetch front-end: owns PCF, issues in-order imem requests under a credit scheme,
// buffers returned instructions and drives the IF/ID pipeline register.
module fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic [1:0]  PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [31:0] ALUResultE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchEmpty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [31:0]   pcf_q, pcf_d;

    // PCs of issued-but-unanswered requests, oldest at pend_rd_q
    logic [31:0]   pend_pc_q [DEPTH];
    logic [AW-1:0] pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
    logic [CW-1:0] pend_cnt_q, pend_cnt_d;

    logic [31:0]   q_instr_q [DEPTH];
    logic [31:0]   q_pc_q [DEPTH];
    logic [AW-1:0] q_head_q, q_head_d, q_tail_q, q_tail_d;
    logic [CW-1:0] q_cnt_q, q_cnt_d;

    logic [CW-1:0] drop_cnt_q, drop_cnt_d;

    logic [31:0]   dec_instr_q, dec_instr_d;
    logic [31:0]   dec_pc_q, dec_pc_d;
    logic [31:0]   dec_pc4_q, dec_pc4_d;
    logic          dec_valid_q, dec_valid_d;

    logic          redirect;
    logic [31:0]   redirect_target;
    logic          pop;
    logic          push;
    logic          issue;
    logic          credit_ok;
    logic [CW:0]   credit_sum;

    assign redirect        = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
    assign redirect_target = (PCSrcE == 2'b10) ? (ALUResultE & ~32'd1) : PCTargetE;

    // Redirect squashes the head too, so no wrong-path instruction reaches decode
    assign pop = !FlushD && !StallD && !redirect && (q_cnt_q != '0);

    // Every request in flight owns a queue slot before it is issued
    assign credit_sum = {1'b0, pend_cnt_q} + {1'b0, q_cnt_q} - {{CW{1'b0}}, pop};
    assign credit_ok  = credit_sum < (CW + 1)'(DEPTH);

    assign imem_req_valid = rst_n && credit_ok && !StallF && !redirect;
    assign imem_addr      = pcf_q;
    assign issue          = imem_req_valid && imem_req_ready;

    assign push = imem_rsp_valid && !redirect && (drop_cnt_q == '0);

    always_comb begin
        pcf_d = pcf_q;
        if (redirect) begin
            pcf_d = redirect_target;
        end else if (issue) begin
            pcf_d = pcf_q + 32'd4;
        end
    end

    always_comb begin
        pend_wr_d  = pend_wr_q + AW'(issue);
        pend_rd_d  = pend_rd_q + AW'(imem_rsp_valid);
        pend_cnt_d = pend_cnt_q + CW'(issue) - CW'(imem_rsp_valid);

        drop_cnt_d = drop_cnt_q;
        if (redirect) begin
            drop_cnt_d = pend_cnt_q - CW'(imem_rsp_valid);
        end else if (imem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_comb begin
        q_head_d = q_head_q;
        q_tail_d = q_tail_q;
        q_cnt_d  = q_cnt_q;
        if (redirect) begin
            q_head_d = '0;
            q_tail_d = '0;
            q_cnt_d  = '0;
        end else begin
            q_head_d = q_head_q + AW'(pop);
            q_tail_d = q_tail_q + AW'(push);
            q_cnt_d  = q_cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        dec_instr_d = dec_instr_q;
        dec_pc_d    = dec_pc_q;
        dec_pc4_d   = dec_pc4_q;
        dec_valid_d = dec_valid_q;
        if (FlushD) begin
            dec_instr_d = NOP_INSTR;
            dec_valid_d = 1'b0;
        end else if (StallD) begin
            dec_valid_d = dec_valid_q;
        end else if (pop) begin
            dec_instr_d = q_instr_q[q_head_q];
            dec_pc_d    = q_pc_q[q_head_q];
            dec_pc4_d   = q_pc_q[q_head_q] + 32'd4;
            dec_valid_d = 1'b1;
        end else begin
            dec_instr_d = NOP_INSTR;
            dec_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf_q       <= RESET_PC;
            pend_rd_q   <= '0;
            pend_wr_q   <= '0;
            pend_cnt_q  <= '0;
            q_head_q    <= '0;
            q_tail_q    <= '0;
            q_cnt_q     <= '0;
            drop_cnt_q  <= '0;
            dec_instr_q <= NOP_INSTR;
            dec_pc_q    <= '0;
            dec_pc4_q   <= '0;
            dec_valid_q <= 1'b0;
        end else begin
            pcf_q       <= pcf_d;
            pend_rd_q   <= pend_rd_d;
            pend_wr_q   <= pend_wr_d;
            pend_cnt_q  <= pend_cnt_d;
            q_head_q    <= q_head_d;
            q_tail_q    <= q_tail_d;
            q_cnt_q     <= q_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            dec_instr_q <= dec_instr_d;
            dec_pc_q    <= dec_pc_d;
            dec_pc4_q   <= dec_pc4_d;
            dec_valid_q <= dec_valid_d;
        end
    end

    // Storage arrays carry no reset; their contents are qualified by the counters
    always_ff @(posedge clk) begin
        if (issue) begin
            pend_pc_q[pend_wr_q] <= pcf_q;
        end
        if (push) begin
            q_instr_q[q_tail_q] <= imem_rsp_data;
            q_pc_q[q_tail_q]    <= pend_pc_q[pend_rd_q];
        end
    end

    assign InstrD     = dec_instr_q;
    assign PCD        = dec_pc_q;
    assign PCPlus4D   = dec_pc4_q;
    assign ValidD     = dec_valid_q;
    assign FetchEmpty = (q_cnt_q == '0);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a fixed-latency in-order instruction memory model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StallF = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic [1:0]  PCSrcE = 2'b00;
    logic [31:0] PCTargetE = '0;
    logic [31:0] ALUResultE = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        FetchEmpty;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    int unsigned lat = 1;
    int unsigned cyc = 0;

    logic [31:0] pend_addr[$];
    int unsigned pend_due[$];

    fetch_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .StallF         (StallF),
        .StallD         (StallD),
        .FlushD         (FlushD),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .ALUResultE     (ALUResultE),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .InstrD         (InstrD),
        .PCD            (PCD),
        .PCPlus4D       (PCPlus4D),
        .ValidD         (ValidD),
        .FetchEmpty     (FetchEmpty)
    );

    always #5 clk = ~clk;

    // Memory: word at address a is DEAD0000 ^ a, returned lat cycles after acceptance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_addr.delete();
            pend_due.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                pend_addr.push_back(imem_addr);
                pend_due.push_back(cyc + lat);
            end
            if (pend_due.size() != 0 && pend_due[0] <= cyc + 1) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= 32'hDEAD_0000 ^ pend_addr[0];
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
        cyc <= cyc + 1;
    end

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hDEAD_0000 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, 32'd0);
        chk({tag, ".addr"}, imem_addr, 32'h0);
        chk({tag, ".instr"}, InstrD, 32'h13);
        chk({tag, ".pcd"}, PCD, 32'h0);
        chk({tag, ".pc4"}, PCPlus4D, 32'h0);
        chk({tag, ".valid"}, {31'd0, ValidD}, 32'd0);
        chk({tag, ".empty"}, {31'd0, FetchEmpty}, 32'd1);
    endtask

    task automatic nx();
        @(negedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into cycle 0
    task automatic reset_dut(input int unsigned l);
        @(negedge clk);
        rst_n = 1'b0;
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 2'b00;
        imem_req_ready = 1'b1;
        lat = l;
        #1;
        chk_reset("rst");
        nx();
        nx();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic chk_dec(input string tag, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'd0, ValidD}, 32'd1);
        chk({tag, ".pcd"}, PCD, pc);
        chk({tag, ".pc4"}, PCPlus4D, pc + 32'd4);
        chk({tag, ".instr"}, InstrD, word(pc));
    endtask

    initial begin
        // Free run, latency 1
        reset_dut(1);
        chk("c0.req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("c0.addr", imem_addr, 32'h0);
        nx();
        chk("c1.addr", imem_addr, 32'h4);
        chk("c1.empty", {31'd0, FetchEmpty}, 32'd1);
        nx();
        chk("c2.empty", {31'd0, FetchEmpty}, 32'd0);
        chk("c2.valid", {31'd0, ValidD}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            nx();
            chk_dec("run", 32'(4 * i));
            chk("run.addr", imem_addr, 32'(4 * (3 + i)));
        end

        // Asynchronous reset mid-stream
        nx();
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");

        // Memory not ready in cycles 1-3
        reset_dut(1);
        chk("rdy.c0.addr", imem_addr, 32'h0);
        nx(); imem_req_ready = 1'b0; #1;
        chk("rdy.c1.addr", imem_addr, 32'h4);
        nx();
        chk("rdy.c2.addr", imem_addr, 32'h4);
        nx();
        chk("rdy.c3.addr", imem_addr, 32'h4);
        chk_dec("rdy.c3", 32'h0);
        nx(); imem_req_ready = 1'b1; #1;
        chk("rdy.c4.addr", imem_addr, 32'h4);
        chk("rdy.c4.valid", {31'd0, ValidD}, 32'd0);
        nx();
        chk("rdy.c5.addr", imem_addr, 32'h8);
        nx();
        chk("rdy.c6.valid", {31'd0, ValidD}, 32'd0);
        nx();
        chk_dec("rdy.c7", 32'h4);
        nx();
        chk_dec("rdy.c8", 32'h8);

        // StallF+StallD for cycles 5-9, then FlushD+StallD in cycle 14
        reset_dut(1);
        repeat (4) nx();
        nx(); StallF = 1'b1; StallD = 1'b1; #1;
        chk("stl.c5.req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("stl.c5.addr", imem_addr, 32'h14);
        chk_dec("stl.c5", 32'h8);
        repeat (4) nx();
        chk_dec("stl.c9", 32'h8);
        chk("stl.c9.addr", imem_addr, 32'h14);
        chk("stl.c9.empty", {31'd0, FetchEmpty}, 32'd0);
        nx(); StallF = 1'b0; StallD = 1'b0; #1;
        chk("stl.c10.req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("stl.c10.addr", imem_addr, 32'h14);
        chk_dec("stl.c10", 32'h8);
        for (int i = 0; i < 4; i++) begin
            nx();
            chk_dec("stl.rel", 32'(32'hC + 4 * i));
        end
        FlushD = 1'b1; StallD = 1'b1;
        nx(); FlushD = 1'b0; StallD = 1'b0; #1;
        chk("flush.instr", InstrD, 32'h13);
        chk("flush.valid", {31'd0, ValidD}, 32'd0);
        chk("flush.pcd", PCD, 32'h18);
        nx();
        chk_dec("flush.next", 32'h1C);

        // Redirects with latency-2 memory
        reset_dut(2);
        repeat (3) nx();
        nx();
        chk_dec("br.c4", 32'h0);
        nx(); PCSrcE = 2'b01; PCTargetE = 32'h100; #1;
        chk("br.c5.req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk_dec("br.c5", 32'h4);
        nx(); PCSrcE = 2'b00; #1;
        chk("br.c6.req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("br.c6.addr", imem_addr, 32'h100);
        chk("br.c6.valid", {31'd0, ValidD}, 32'd0);
        chk("br.c6.empty", {31'd0, FetchEmpty}, 32'd1);
        nx();
        chk("br.c7.addr", imem_addr, 32'h104);
        chk("br.c7.empty", {31'd0, FetchEmpty}, 32'd1);
        chk("br.c7.valid", {31'd0, ValidD}, 32'd0);
        nx();
        chk("br.c8.empty", {31'd0, FetchEmpty}, 32'd1);
        chk("br.c8.valid", {31'd0, ValidD}, 32'd0);
        nx();
        chk("br.c9.empty", {31'd0, FetchEmpty}, 32'd0);
        chk("br.c9.valid", {31'd0, ValidD}, 32'd0);
        nx();
        chk_dec("br.c10", 32'h100);
        nx();
        chk_dec("br.c11", 32'h104);
        nx(); PCSrcE = 2'b10; ALUResultE = 32'h203; #1;
        chk("jr.c12.req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk_dec("jr.c12", 32'h108);
        nx(); PCSrcE = 2'b00; #1;
        chk("jr.c13.addr", imem_addr, 32'h202);
        chk("jr.c13.req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("jr.c13.valid", {31'd0, ValidD}, 32'd0);
        nx();
        chk("jr.c14.valid", {31'd0, ValidD}, 32'd0);
        nx();
        chk("jr.c15.valid", {31'd0, ValidD}, 32'd0);
        nx();
        chk("jr.c16.valid", {31'd0, ValidD}, 32'd0);
        nx();
        chk_dec("jr.c17", 32'h202);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
